// File: rtl/cook_time_entry.sv
// cook_time_entry
// Front-panel programming controller for the egg timer. Converts debounced
// button levels into four BCD cook-time digits plus the load / main_enable
// controls for time_count, and reacts to the counter's done flag.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   tick_en             1 s enable pulse, used only for auto-repeat timing
//   btn_sel/inc/dec     digit select, increment, decrement (levels)
//   btn_start           start / pause / resume (level)
//   timer_done          done flag from time_count
//   *_prog              programmed BCD digits (units 0-9, tens 0-5)
//   load                one-cycle load strobe to time_count
//   timer_on            main_enable for time_count
//   edit_digit          currently selected digit (0 = seconds .. 3 = tens_minutes)
//   editing, alarm      status flags for the EDIT and DONE states
module cook_time_entry #(
    parameter int REPEAT_DELAY = 5,
    parameter int REPEAT_RATE  = 2,
    parameter int CNT_WIDTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_start,
    input  logic       timer_done,
    output logic [3:0] seconds_prog,
    output logic [3:0] tens_seconds_prog,
    output logic [3:0] minutes_prog,
    output logic [3:0] tens_minutes_prog,
    output logic       load,
    output logic       timer_on,
    output logic [1:0] edit_digit,
    output logic       editing,
    output logic       alarm
);

    typedef enum logic [2:0] {ST_EDIT, ST_LOAD, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    // Terminal counts: the step fires on the pulse that brings the count to the threshold.
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);

    state_t               state, state_next;
    logic                 sel_q, inc_q, dec_q, start_q;
    logic                 armed;
    logic                 sel_p, inc_p, dec_p, start_p, any_p;
    logic [3:0]           digits      [4];
    logic [3:0]           digits_next [4];
    logic [1:0]           edit_digit_next;
    logic [CNT_WIDTH-1:0] rep_cnt, rep_cnt_next;
    logic                 hold_valid, hold_valid_next;
    logic                 repeating, repeating_next;
    logic                 hold_cond, repeat_step, press_step;
    logic                 step_up, step_dn, digits_zero;
    logic [3:0]           sel_max, sel_val;
    logic                 load_next, timer_on_next, editing_next, alarm_next;

    // armed stays low for the first edge after reset so a button held through
    // reset deassertion is only recorded in history, never seen as a press.
    assign sel_p   = armed & btn_sel   & ~sel_q;
    assign inc_p   = armed & btn_inc   & ~inc_q;
    assign dec_p   = armed & btn_dec   & ~dec_q;
    assign start_p = armed & btn_start & ~start_q;
    assign any_p   = sel_p | inc_p | dec_p | start_p;

    assign digits_zero = (digits[0] == 4'd0) && (digits[1] == 4'd0) &&
                         (digits[2] == 4'd0) && (digits[3] == 4'd0);

    // Auto-repeat only runs while exactly one of inc/dec is held alone in EDIT,
    // and only if that hold began with a real press (hold_valid).
    assign hold_cond   = (state == ST_EDIT) && (btn_inc ^ btn_dec) && !btn_sel && !btn_start;
    assign repeat_step = hold_cond && hold_valid && tick_en &&
                         (rep_cnt == (repeating ? RATE_LAST : DELAY_LAST));

    // State register together with the registered outputs and button history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EDIT;
            load     <= 1'b0;
            timer_on <= 1'b0;
            editing  <= 1'b1;
            alarm    <= 1'b0;
            sel_q    <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            start_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            load     <= load_next;
            timer_on <= timer_on_next;
            editing  <= editing_next;
            alarm    <= alarm_next;
            sel_q    <= btn_sel;
            inc_q    <= btn_inc;
            dec_q    <= btn_dec;
            start_q  <= btn_start;
            armed    <= 1'b1;
        end
    end

    // Next-state logic. In RUN, timer_done outranks a start press.
    always_comb begin
        state_next = state;
        case (state)
            ST_EDIT:  if (start_p && !digits_zero) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            ST_RUN: begin
                if (timer_done)   state_next = ST_DONE;
                else if (start_p) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_p)    state_next = ST_RUN;
                else if (sel_p) state_next = ST_EDIT;
            end
            ST_DONE:  if (any_p) state_next = ST_EDIT;
            default:  state_next = ST_EDIT;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered and
    // line up with the state they describe.
    always_comb begin
        load_next     = (state_next == ST_LOAD);
        timer_on_next = (state_next == ST_RUN);
        editing_next  = (state_next == ST_EDIT);
        alarm_next    = (state_next == ST_DONE);
    end

    // Digit editing and auto-repeat. A start press in EDIT consumes the cycle
    // even when it is ignored because all digits are zero.
    always_comb begin
        digits_next     = digits;
        edit_digit_next = edit_digit;
        rep_cnt_next    = rep_cnt;
        hold_valid_next = hold_valid;
        repeating_next  = repeating;
        step_up         = 1'b0;
        step_dn         = 1'b0;
        press_step      = 1'b0;
        if (state == ST_EDIT && !start_p) begin
            if (sel_p) begin
                edit_digit_next = edit_digit + 2'd1;
            end else if (inc_p && !dec_p) begin
                step_up    = 1'b1;
                press_step = 1'b1;
            end else if (dec_p && !inc_p) begin
                step_dn    = 1'b1;
                press_step = 1'b1;
            end else if (repeat_step) begin
                step_up = btn_inc;
                step_dn = btn_dec;
            end
        end

        sel_max = edit_digit[0] ? 4'd5 : 4'd9;
        sel_val = digits[edit_digit];
        if (step_up) digits_next[edit_digit] = (sel_val == sel_max) ? 4'd0 : sel_val + 4'd1;
        if (step_dn) digits_next[edit_digit] = (sel_val == 4'd0) ? sel_max : sel_val - 4'd1;

        if (!hold_cond) begin
            rep_cnt_next    = '0;
            hold_valid_next = 1'b0;
            repeating_next  = 1'b0;
        end else if (press_step) begin
            rep_cnt_next    = '0;
            hold_valid_next = 1'b1;
            repeating_next  = 1'b0;
        end else if (hold_valid && tick_en) begin
            if (repeat_step) begin
                rep_cnt_next   = '0;
                repeating_next = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
            edit_digit <= 2'd0;
            rep_cnt    <= '0;
            hold_valid <= 1'b0;
            repeating  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) digits[i] <= digits_next[i];
            edit_digit <= edit_digit_next;
            rep_cnt    <= rep_cnt_next;
            hold_valid <= hold_valid_next;
            repeating  <= repeating_next;
        end
    end

    assign seconds_prog      = digits[0];
    assign tens_seconds_prog = digits[1];
    assign minutes_prog      = digits[2];
    assign tens_minutes_prog = digits[3];

endmodule
